// File: rtl/tx_fc_credit_gate_pkg.sv
// Shared types and default widths for the TX arbiter flow-control credit gate.
package Tx_Arbiter_Package;

    localparam int unsigned DEF_HDR_CREDIT_W  = 8;
    localparam int unsigned DEF_DATA_CREDIT_W = 12;
    localparam int unsigned NUM_FC_CLASS      = 3;

    typedef enum logic [1:0] {
        FC_P    = 2'b00,
        FC_NP   = 2'b01,
        FC_CPL  = 2'b10,
        FC_RSVD = 2'b11
    } fc_type_t;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_CHECK,
        ST_GRANT
    } fc_state_t;

endpackage

// File: rtl/tx_fc_credit_gate_class_tracker.sv
// Per-class credit limits, consumed counters, infinite flags and the
// modular credit-sufficiency check for one flow-control class.
module tx_fc_class_tracker #(
    parameter int unsigned HDR_W  = 8,
    parameter int unsigned DATA_W = 12
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              init_mode,
    input  logic              upd_valid,
    input  logic [HDR_W-1:0]  upd_hdr,
    input  logic [DATA_W-1:0] upd_data,
    input  logic [DATA_W-1:0] chk_dcred,
    input  logic              consume,
    input  logic [DATA_W-1:0] cns_dcred,
    output logic              pass_c
);

    localparam logic [HDR_W-1:0]  HDR_HALF  = HDR_W'(1) << (HDR_W - 1);
    localparam logic [DATA_W-1:0] DATA_HALF = DATA_W'(1) << (DATA_W - 1);

    logic [HDR_W-1:0]  hdr_lim;
    logic [HDR_W-1:0]  hdr_cons;
    logic              hdr_inf;
    logic [DATA_W-1:0] data_lim;
    logic [DATA_W-1:0] data_cons;
    logic              data_inf;
    logic [HDR_W-1:0]  hdr_room;
    logic [DATA_W-1:0] data_room;

    // Remaining credits after this TLP, interpreted modulo 2^W
    assign hdr_room  = hdr_lim - (hdr_cons + HDR_W'(1));
    assign data_room = data_lim - (data_cons + chk_dcred);
    assign pass_c    = (hdr_inf || (hdr_room <= HDR_HALF)) &&
                       (data_inf || (data_room <= DATA_HALF));

    always_ff @(posedge clk) begin
        if (arst) begin
            hdr_lim   <= '0;
            hdr_cons  <= '0;
            hdr_inf   <= 1'b0;
            data_lim  <= '0;
            data_cons <= '0;
            data_inf  <= 1'b0;
        end else begin
            // During init a zero limit means unlimited; afterwards infinite fields are frozen
            if (upd_valid) begin
                if (init_mode) begin
                    hdr_lim  <= upd_hdr;
                    hdr_inf  <= (upd_hdr == '0);
                    data_lim <= upd_data;
                    data_inf <= (upd_data == '0);
                end else begin
                    if (!hdr_inf)  hdr_lim  <= upd_hdr;
                    if (!data_inf) data_lim <= upd_data;
                end
            end
            if (consume) begin
                if (!hdr_inf)  hdr_cons  <= hdr_cons + HDR_W'(1);
                if (!data_inf) data_cons <= data_cons + cns_dcred;
            end
        end
    end

endmodule

// File: rtl/tx_fc_credit_gate.sv
// Flow-control credit gate: holds the sequence-recorder head until the link
// partner has advertised enough credits. Optional stall monitor: TX_FC_STALL_MON_EN.
module tx_fc_credit_gate
    import Tx_Arbiter_Package::*;
#(
    parameter int unsigned HDR_CREDIT_W  = DEF_HDR_CREDIT_W,
    parameter int unsigned DATA_CREDIT_W = DEF_DATA_CREDIT_W,
    parameter int unsigned STALL_LIMIT   = 1024
) (
    input  logic                     clk,
    input  logic                     arst,
    input  logic                     seq_empty,
    input  logic [1:0]               seq_src,
    input  logic [1:0]               seq_type,
    input  logic [DATA_CREDIT_W-1:0] seq_dcred,
    output logic                     seq_rd,
    input  logic                     fc_init_done,
    input  logic                     fc_upd_valid,
    input  logic [1:0]               fc_upd_type,
    input  logic [HDR_CREDIT_W-1:0]  fc_upd_hdr,
    input  logic [DATA_CREDIT_W-1:0] fc_upd_data,
    output logic                     grant_valid,
    output logic [1:0]               grant_src,
    input  logic                     grant_ready,
    output logic                     fc_stall
);

    fc_state_t                state;
    fc_state_t                state_next;
    logic [1:0]               src_q;
    fc_type_t                 type_q;
    logic [DATA_CREDIT_W-1:0] dcred_q;
    fc_type_t                 head_type;
    logic                     head_pass_c;
    logic                     handshake_c;
    logic [NUM_FC_CLASS-1:0]  cls_pass;
    logic [NUM_FC_CLASS-1:0]  cls_upd;
    logic [NUM_FC_CLASS-1:0]  cls_cons;

    assign head_type   = fc_type_t'(seq_type);
    assign handshake_c = (state == ST_GRANT) && grant_valid && grant_ready && !arst;
    assign seq_rd      = handshake_c;
    assign grant_src   = src_q;

    // Reserved class bypasses credit accounting entirely
    always_comb begin
        head_pass_c = 1'b1;
        case (head_type)
            FC_P:    head_pass_c = cls_pass[0];
            FC_NP:   head_pass_c = cls_pass[1];
            FC_CPL:  head_pass_c = cls_pass[2];
            default: head_pass_c = 1'b1;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (fc_init_done) state_next = ST_IDLE;
            ST_IDLE:  if (!seq_empty)   state_next = ST_CHECK;
            ST_CHECK: if (head_pass_c)  state_next = ST_GRANT;
            ST_GRANT: if (handshake_c)  state_next = ST_IDLE;
            default:  state_next = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            state       <= ST_INIT;
            grant_valid <= 1'b0;
            src_q       <= 2'b00;
            type_q      <= FC_P;
            dcred_q     <= '0;
        end else begin
            state       <= state_next;
            grant_valid <= (state_next == ST_GRANT);
            if (state == ST_CHECK) begin
                src_q   <= seq_src;
                type_q  <= head_type;
                dcred_q <= seq_dcred;
            end
        end
    end

    for (genvar c = 0; c < NUM_FC_CLASS; c++) begin : g_cls
        assign cls_upd[c]  = fc_upd_valid && (fc_upd_type == 2'(c));
        assign cls_cons[c] = handshake_c && (type_q == fc_type_t'(2'(c)));

        tx_fc_class_tracker #(
            .HDR_W  (HDR_CREDIT_W),
            .DATA_W (DATA_CREDIT_W)
        ) u_trk (
            .clk       (clk),
            .arst      (arst),
            .init_mode (state == ST_INIT),
            .upd_valid (cls_upd[c]),
            .upd_hdr   (fc_upd_hdr),
            .upd_data  (fc_upd_data),
            .chk_dcred (seq_dcred),
            .consume   (cls_cons[c]),
            .cns_dcred (dcred_q),
            .pass_c    (cls_pass[c])
        );
    end

`ifdef TX_FC_STALL_MON_EN
    localparam int unsigned          STALL_W   = $clog2(STALL_LIMIT + 1);
    localparam logic [STALL_W-1:0]   STALL_MAX = STALL_W'(STALL_LIMIT);

    logic [STALL_W-1:0] stall_cnt;
    logic [STALL_W-1:0] stall_cnt_next;

    // Saturating count of consecutive failed CHECK cycles
    always_comb begin
        stall_cnt_next = '0;
        if ((state == ST_CHECK) && !head_pass_c) begin
            stall_cnt_next = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (arst) begin
            stall_cnt <= '0;
            fc_stall  <= 1'b0;
        end else begin
            stall_cnt <= stall_cnt_next;
            fc_stall  <= (stall_cnt_next == STALL_MAX);
        end
    end
`else
    logic unused_stall_limit;
    assign unused_stall_limit = ^32'(STALL_LIMIT);
    assign fc_stall           = 1'b0;
`endif

endmodule

// File: tb/tb_tx_fc_credit_gate.sv
// Scoreboard bench for tx_fc_credit_gate: a queue models the sequence recorder,
// expected grant sources are queued at push time and checked on each handshake.
module tb_tx_fc_credit_gate;

    localparam int unsigned HW = 8;
    localparam int unsigned DW = 12;
    localparam int unsigned SL = 16;

    logic          clk = 1'b0;
    logic          arst = 1'b1;
    logic          seq_empty = 1'b1;
    logic [1:0]    seq_src = 2'b00;
    logic [1:0]    seq_type = 2'b00;
    logic [DW-1:0] seq_dcred = '0;
    logic          seq_rd;
    logic          fc_init_done = 1'b0;
    logic          fc_upd_valid = 1'b0;
    logic [1:0]    fc_upd_type = 2'b00;
    logic [HW-1:0] fc_upd_hdr = '0;
    logic [DW-1:0] fc_upd_data = '0;
    logic          grant_valid;
    logic [1:0]    grant_src;
    logic          grant_ready = 1'b1;
    logic          fc_stall;

    typedef struct {
        logic [1:0]    src;
        logic [1:0]    typ;
        logic [DW-1:0] dcred;
    } tlp_t;

    tlp_t       fifo[$];
    logic [1:0] exp_q[$];
    int         chk_cnt = 0;
    int         pass_cnt = 0;
    int         grant_cnt = 0;
    int         pop_cnt = 0;

    always #5 clk = ~clk;

    tx_fc_credit_gate #(
        .HDR_CREDIT_W  (HW),
        .DATA_CREDIT_W (DW),
        .STALL_LIMIT   (SL)
    ) dut (
        .clk          (clk),
        .arst         (arst),
        .seq_empty    (seq_empty),
        .seq_src      (seq_src),
        .seq_type     (seq_type),
        .seq_dcred    (seq_dcred),
        .seq_rd       (seq_rd),
        .fc_init_done (fc_init_done),
        .fc_upd_valid (fc_upd_valid),
        .fc_upd_type  (fc_upd_type),
        .fc_upd_hdr   (fc_upd_hdr),
        .fc_upd_data  (fc_upd_data),
        .grant_valid  (grant_valid),
        .grant_src    (grant_src),
        .grant_ready  (grant_ready),
        .fc_stall     (fc_stall)
    );

    task automatic drive_head();
        if (fifo.size() == 0) begin
            seq_empty = 1'b1;
            seq_src   = 2'b00;
            seq_type  = 2'b00;
            seq_dcred = '0;
        end else begin
            seq_empty = 1'b0;
            seq_src   = fifo[0].src;
            seq_type  = fifo[0].typ;
            seq_dcred = fifo[0].dcred;
        end
    endtask

    // One clock cycle: scoreboard the current cycle, then advance to posedge+1
    task automatic tick();
        logic [1:0] exp_src;
        tlp_t       tmp;
        #1;
        if (!arst && grant_valid === 1'b1 && grant_ready === 1'b1) begin
            grant_cnt++;
            chk_cnt++;
            if (seq_rd !== 1'b1) $display("FAIL handshake_pop: seq_rd=%b required 1", seq_rd);
            else pass_cnt++;
            chk_cnt++;
            if (exp_q.size() == 0) begin
                $display("FAIL grant_src: unexpected grant src=%0d, no grant required", grant_src);
            end else begin
                exp_src = exp_q.pop_front();
                if (grant_src !== exp_src) $display("FAIL grant_src: got %0d required %0d", grant_src, exp_src);
                else pass_cnt++;
            end
        end else if (seq_rd === 1'b1) begin
            chk_cnt++;
            $display("FAIL spurious_pop: seq_rd=1 without handshake (arst=%b gv=%b rdy=%b)",
                     arst, grant_valid, grant_ready);
        end
        if (seq_rd === 1'b1) begin
            pop_cnt++;
            if (fifo.size() > 0) tmp = fifo.pop_front();
            drive_head();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic push_tlp(input logic [1:0] src, input logic [1:0] typ,
                            input logic [DW-1:0] dcred, input bit expect_grant);
        tlp_t t;
        t.src   = src;
        t.typ   = typ;
        t.dcred = dcred;
        fifo.push_back(t);
        if (expect_grant) exp_q.push_back(src);
        drive_head();
    endtask

    task automatic send_upd(input logic [1:0] typ, input logic [HW-1:0] hdr, input logic [DW-1:0] data);
        fc_upd_valid = 1'b1;
        fc_upd_type  = typ;
        fc_upd_hdr   = hdr;
        fc_upd_data  = data;
        tick();
        fc_upd_valid = 1'b0;
    endtask

    task automatic do_reset();
        arst         = 1'b1;
        grant_ready  = 1'b1;
        fc_init_done = 1'b0;
        fc_upd_valid = 1'b0;
        fifo.delete();
        exp_q.delete();
        drive_head();
        tick();
        tick();
        arst = 1'b0;
    endtask

    task automatic init_fc(input logic [HW-1:0] p_h, input logic [DW-1:0] p_d,
                           input logic [HW-1:0] np_h, input logic [DW-1:0] np_d,
                           input logic [HW-1:0] c_h, input logic [DW-1:0] c_d);
        send_upd(2'b00, p_h, p_d);
        send_upd(2'b01, np_h, np_d);
        send_upd(2'b10, c_h, c_d);
        fc_init_done = 1'b1;
        tick();
    endtask

    task automatic wait_drain(input string name, input int limit);
        for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
        chk_cnt++;
        if (exp_q.size() != 0) $display("FAIL %s_drain: %0d grants outstanding, required 0", name, exp_q.size());
        else pass_cnt++;
    endtask

    task automatic test_reset();
        do_reset();
        chk_cnt++;
        if (grant_valid !== 1'b0) $display("FAIL reset_gv: got %b required 0", grant_valid); else pass_cnt++;
        chk_cnt++;
        if (grant_src !== 2'b00) $display("FAIL reset_src: got %0d required 0", grant_src); else pass_cnt++;
        chk_cnt++;
        if (fc_stall !== 1'b0) $display("FAIL reset_stall: got %b required 0", fc_stall); else pass_cnt++;
        chk_cnt++;
        if (seq_rd !== 1'b0) $display("FAIL reset_seq_rd: got %b required 0", seq_rd); else pass_cnt++;
        push_tlp(2'd1, 2'b00, 12'd1, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        chk_cnt++;
        if (grant_valid !== 1'b0) $display("FAIL init_hold_gv: got %b required 0", grant_valid); else pass_cnt++;
        chk_cnt++;
        if (fifo.size() != 1) $display("FAIL init_hold_fifo: size %0d required 1", fifo.size()); else pass_cnt++;
    endtask

    task automatic test_credit_limits();
        int g0;
        do_reset();
        init_fc(8'd4, 12'd8, 8'd0, 12'd0, 8'd0, 12'd0);
        g0 = grant_cnt;
        for (int i = 0; i < 4; i++) push_tlp(2'(i), 2'b00, 12'd2, 1'b1);
        wait_drain("p_four", 60);
        chk_cnt++;
        if (grant_cnt - g0 != 4) $display("FAIL p_four_count: got %0d required 4", grant_cnt - g0);
        else pass_cnt++;
        push_tlp(2'd1, 2'b00, 12'd2, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk_cnt++;
        if (grant_valid !== 1'b0) $display("FAIL p_fifth_blocked: gv=%b required 0", grant_valid); else pass_cnt++;
        chk_cnt++;
        if (fifo.size() != 1) $display("FAIL p_fifth_fifo: size %0d required 1", fifo.size()); else pass_cnt++;
    endtask

    task automatic test_limit_update();
        int p0;
        grant_ready = 1'b0;
        exp_q.push_back(2'd1);
        send_upd(2'b00, 8'd5, 12'd10);
        chk_cnt++;
        if (grant_valid !== 1'b0) $display("FAIL upd_lat1: gv=%b required 0", grant_valid); else pass_cnt++;
        tick();
        chk_cnt++;
        if (grant_valid !== 1'b1) $display("FAIL upd_lat2: gv=%b required 1", grant_valid); else pass_cnt++;
        p0 = pop_cnt;
        grant_ready = 1'b1;
        tick();
        chk_cnt++;
        if (pop_cnt != p0 + 1) $display("FAIL upd_pop: pops %0d required %0d", pop_cnt - p0, 1); else pass_cnt++;
        for (int i = 0; i < 3; i++) tick();
        chk_cnt++;
        if (pop_cnt != p0 + 1 || fifo.size() != 0)
            $display("FAIL upd_single_pop: pops %0d fifo %0d required 1 and 0", pop_cnt - p0, fifo.size());
        else pass_cnt++;
    endtask

    task automatic test_latency();
        grant_ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk_cnt++;
        if (grant_valid !== 1'b0) $display("FAIL lat_n0: gv=%b required 0", grant_valid); else pass_cnt++;
        push_tlp(2'd2, 2'b01, 12'd7, 1'b1);
        tick();
        chk_cnt++;
        if (grant_valid !== 1'b0) $display("FAIL lat_n1: gv=%b required 0", grant_valid); else pass_cnt++;
        tick();
        chk_cnt++;
        if (grant_valid !== 1'b1 || grant_src !== 2'd2)
            $display("FAIL lat_n2: gv=%b src=%0d required 1 and 2", grant_valid, grant_src);
        else pass_cnt++;
        wait_drain("latency", 10);
    endtask

    task automatic test_ready_hold();
        int p0;
        grant_ready = 1'b0;
        push_tlp(2'd3, 2'b01, 12'd5, 1'b1);
        for (int i = 0; i < 10 && grant_valid !== 1'b1; i++) tick();
        chk_cnt++;
        if (grant_valid !== 1'b1) $display("FAIL hold_rise: gv=%b required 1", grant_valid); else pass_cnt++;
        p0 = pop_cnt;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_cnt++;
            if (grant_valid !== 1'b1 || grant_src !== 2'd3)
                $display("FAIL hold_stable: cycle %0d gv=%b src=%0d required 1 and 3", i, grant_valid, grant_src);
            else pass_cnt++;
        end
        chk_cnt++;
        if (pop_cnt != p0) $display("FAIL hold_no_pop: pops %0d required 0", pop_cnt - p0); else pass_cnt++;
        grant_ready = 1'b1;
        tick();
        chk_cnt++;
        if (pop_cnt != p0 + 1) $display("FAIL hold_pop: pops %0d required 1", pop_cnt - p0); else pass_cnt++;
    endtask

    task automatic test_reset_in_grant();
        grant_ready = 1'b0;
        push_tlp(2'd1, 2'b01, 12'd0, 1'b1);
        for (int i = 0; i < 10 && grant_valid !== 1'b1; i++) tick();
        arst         = 1'b1;
        grant_ready  = 1'b1;
        fc_init_done = 1'b0;
        tick();
        arst = 1'b0;
        chk_cnt++;
        if (grant_valid !== 1'b0) $display("FAIL rst_grant_gv: gv=%b required 0", grant_valid); else pass_cnt++;
        chk_cnt++;
        if (fifo.size() != 1) $display("FAIL rst_grant_fifo: size %0d required 1", fifo.size()); else pass_cnt++;
        init_fc(8'd0, 12'd0, 8'd0, 12'd0, 8'd0, 12'd0);
        wait_drain("rearb", 20);
    endtask

    task automatic test_infinite();
        int g0;
        do_reset();
        init_fc(8'd4, 12'd8, 8'd0, 12'd0, 8'd0, 12'd0);
        g0 = grant_cnt;
        for (int i = 0; i < 100; i++) push_tlp(2'($urandom_range(0, 3)), 2'b01, DW'($urandom), 1'b1);
        wait_drain("np_inf", 1000);
        chk_cnt++;
        if (grant_cnt - g0 != 100) $display("FAIL np_inf_count: got %0d required 100", grant_cnt - g0);
        else pass_cnt++;
        send_upd(2'b01, 8'd5, 12'd5);
        push_tlp(2'd0, 2'b01, 12'd100, 1'b1);
        wait_drain("np_upd_ignored", 20);
    endtask

    task automatic test_wrap();
        do_reset();
        init_fc(8'd100, 12'd0, 8'd0, 12'd0, 8'd0, 12'd0);
        for (int i = 0; i < 100; i++) push_tlp(2'($urandom_range(0, 3)), 2'b00, DW'($urandom), 1'b1);
        wait_drain("wrap_b1", 600);
        send_upd(2'b00, 8'd200, 12'd0);
        for (int i = 0; i < 100; i++) push_tlp(2'($urandom_range(0, 3)), 2'b00, DW'($urandom), 1'b1);
        wait_drain("wrap_b2", 600);
        send_upd(2'b00, 8'd254, 12'd0);
        for (int i = 0; i < 54; i++) push_tlp(2'($urandom_range(0, 3)), 2'b00, DW'($urandom), 1'b1);
        wait_drain("wrap_b3", 400);
        send_upd(2'b00, 8'd2, 12'd0);
        push_tlp(2'd2, 2'b00, 12'd3, 1'b1);
        wait_drain("wrap_pass", 20);
        send_upd(2'b00, 8'd255, 12'd0);
        push_tlp(2'd3, 2'b00, 12'd1, 1'b0);
        for (int i = 0; i < 10; i++) tick();
        chk_cnt++;
        if (grant_valid !== 1'b0 || fifo.size() != 1)
            $display("FAIL wrap_consumed_255: gv=%b fifo=%0d required 0 and 1", grant_valid, fifo.size());
        else pass_cnt++;
    endtask

    task automatic test_stall();
        logic exp_stall;
`ifdef TX_FC_STALL_MON_EN
        exp_stall = 1'b1;
`else
        exp_stall = 1'b0;
`endif
        do_reset();
        init_fc(8'd0, 12'd0, 8'd0, 12'd0, 8'd1, 12'd8);
        push_tlp(2'd3, 2'b10, 12'd8, 1'b1);
        wait_drain("cpl_first", 20);
        for (int i = 0; i < 3; i++) tick();
        grant_ready = 1'b0;
        push_tlp(2'd2, 2'b10, 12'd1, 1'b1);
        for (int i = 0; i < 16; i++) tick();
        chk_cnt++;
        if (fc_stall !== 1'b0) $display("FAIL stall_early: got %b required 0", fc_stall); else pass_cnt++;
        tick();
        chk_cnt++;
        if (fc_stall !== exp_stall) $display("FAIL stall_set: got %b required %b", fc_stall, exp_stall); else pass_cnt++;
        for (int i = 0; i < 3; i++) tick();
        chk_cnt++;
        if (fc_stall !== exp_stall || grant_valid !== 1'b0)
            $display("FAIL stall_sat: stall=%b gv=%b required %b and 0", fc_stall, grant_valid, exp_stall);
        else pass_cnt++;
        send_upd(2'b10, 8'd2, 12'd16);
        tick();
        chk_cnt++;
        if (grant_valid !== 1'b1 || fc_stall !== 1'b0)
            $display("FAIL stall_clear: gv=%b stall=%b required 1 and 0", grant_valid, fc_stall);
        else pass_cnt++;
        grant_ready = 1'b1;
        wait_drain("cpl_after_upd", 10);
    endtask

    initial begin
        drive_head();
        test_reset();
        test_credit_limits();
        test_limit_update();
        test_latency();
        test_ready_hold();
        test_reset_in_grant();
        test_infinite();
        test_wrap();
        test_stall();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: bench did not finish, %0d/%0d so far", pass_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule
